// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle between the scanner and its surroundings.
// slave: the scanner side; master: the keypad/capture side.
interface keypad_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );

    modport slave (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: active-low column drive, synchronized row sampling,
// press/release debounce, hex code plus one-cycle strobe. DEBOUNCE_CNT >= 2.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 20
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.slave   kp
);
    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT - 1);

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] PRESSED  = 2'd2;

    logic [3:0]    row_m;
    logic [3:0]    row_s;
    logic [DW-1:0] dwell;
    logic          sample;
    logic [1:0]    state;
    logic [1:0]    col_idx;
    logic [CW-1:0] deb;
    logic [3:0]    lat_pat;
    logic [3:0]    lat_code;
    logic [3:0]    code_q;
    logic          valid_q;
    logic          held_q;
    logic          row_ok;
    logic [1:0]    row_idx;

    // Column drive is decoded from an index so it is always exactly one-low.
    assign kp.col_out   = ~(4'b0001 << col_idx);
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;

    assign sample = (dwell == DWELL_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_m <= '1;
            row_s <= '1;
        end else begin
            row_m <= kp.row_in;
            row_s <= row_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell <= '0;
        end else if (sample) begin
            dwell <= '0;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    // Exactly one low row is a press; none or several (ghosting) is no key.
    always_comb begin
        row_ok  = 1'b1;
        row_idx = 2'd0;
        case (row_s)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= SCAN;
            col_idx  <= '0;
            deb      <= '0;
            lat_pat  <= '1;
            lat_code <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (sample) begin
                case (state)
                    SCAN: begin
                        if (row_ok) begin
                            lat_pat  <= row_s;
                            lat_code <= {row_idx, col_idx};
                            deb      <= CW'(1);
                            state    <= DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 1'b1;
                        end
                    end
                    DEBOUNCE: begin
                        if (row_s == lat_pat) begin
                            if (deb == DEB_LAST) begin
                                code_q  <= lat_code;
                                valid_q <= 1'b1;
                                held_q  <= 1'b1;
                                deb     <= '0;
                                state   <= PRESSED;
                            end else begin
                                deb <= deb + 1'b1;
                            end
                        end else begin
                            deb     <= '0;
                            state   <= SCAN;
                            col_idx <= col_idx + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (row_s == 4'b1111) begin
                            if (deb == DEB_LAST) begin
                                held_q  <= 1'b0;
                                deb     <= '0;
                                state   <= SCAN;
                                col_idx <= col_idx + 1'b1;
                            end else begin
                                deb <= deb + 1'b1;
                            end
                        end else begin
                            deb <= '0;
                        end
                    end
                    default: begin
                        deb   <= '0;
                        state <= SCAN;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives the rows,
// expected key codes are queued at press time and popped on each key_valid strobe.
module tb_keypad_scanner;
    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned DEBOUNCE_CNT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] keys = '0;
    logic [3:0]  row_drv;
    logic        prev_valid = 1'b0;
    logic [3:0]  exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_strobe = 0;
    int          s0;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    always #5 clk = ~clk;

    // Row r is pulled low when a pressed key in row r sits on the driven column.
    always_comb begin
        row_drv = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kif.col_out[c]) row_drv[r] = 1'b0;
    end
    assign kif.row_in = row_drv;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (kif.key_valid) begin
            n_strobe++;
            check_val("valid_pulse_width", {31'd0, prev_valid}, 32'd0);
            check_val("held_at_strobe", {31'd0, kif.key_held}, 32'd1);
            if (exp_q.size() == 0) check_val("unexpected_valid", exp_q.size(), 32'd1);
            else check_val("key_code", {28'd0, kif.key_code}, {28'd0, exp_q.pop_front()});
        end
        check_val("col_one_low", $countones(~kif.col_out), 32'd1);
        prev_valid = kif.key_valid;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_col(input int c, input int budget);
        logic [3:0] target;
        int n;
        n = 0;
        target = ~(4'b0001 << c);
        while (kif.col_out == target && n < budget) begin tick(); n++; end
        while (kif.col_out != target && n < budget) begin tick(); n++; end
        if (kif.col_out != target) check_val("wait_col_timeout", {28'd0, kif.col_out}, {28'd0, target});
    endtask

    task automatic wait_strobe(input int target, input int budget);
        int n;
        n = 0;
        while (n_strobe < target && n < budget) begin tick(); n++; end
        if (n_strobe < target) check_val("strobe_timeout", n_strobe, target);
    endtask

    task automatic wait_release(input int budget);
        int n;
        n = 0;
        while (kif.key_held && n < budget) begin tick(); n++; end
        check_val("release_held", {31'd0, kif.key_held}, 32'd0);
    endtask

    initial begin
        logic [3:0] exp_col;

        // reset state, no clock edge yet
        #2;
        check_val("rst_col", {28'd0, kif.col_out}, 32'he);
        check_val("rst_code", {28'd0, kif.key_code}, 32'd0);
        check_val("rst_valid", {31'd0, kif.key_valid}, 32'd0);
        check_val("rst_held", {31'd0, kif.key_held}, 32'd0);

        // 1: idle scan, 4 clocks per column
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 32; k++) begin
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            check_val("t1_col", {28'd0, kif.col_out}, {28'd0, exp_col});
            check_val("t1_held", {31'd0, kif.key_held}, 32'd0);
            tick();
        end
        check_val("t1_strobes", n_strobe, 32'd0);

        // 3: key(2,1) seen on two samples only, then released
        wait_col(1, 64);
        keys[9] = 1'b1;
        repeat (8) tick();
        keys[9] = 1'b0;
        repeat (4) tick();
        check_val("t3_col", {28'd0, kif.col_out}, 32'hb);
        check_val("t3_held", {31'd0, kif.key_held}, 32'd0);
        check_val("t3_strobes", n_strobe, 32'd0);

        // 2: hold key(2,1)
        s0 = n_strobe;
        keys[9] = 1'b1;
        exp_q.push_back(4'h9);
        wait_strobe(s0 + 1, 100);
        check_val("t2_code", {28'd0, kif.key_code}, 32'h9);
        check_val("t2_held", {31'd0, kif.key_held}, 32'd1);
        for (int k = 0; k < 40; k++) begin
            check_val("t2_col_frozen", {28'd0, kif.col_out}, 32'hd);
            tick();
        end
        check_val("t2_single_strobe", n_strobe, s0 + 1);

        // 4: release needs three all-ones samples, then key(0,0)
        keys[9] = 1'b0;
        repeat (10) tick();
        check_val("t4_held_early", {31'd0, kif.key_held}, 32'd1);
        repeat (4) tick();
        check_val("t4_held_late", {31'd0, kif.key_held}, 32'd0);
        check_val("t4_col_next", {28'd0, kif.col_out}, 32'hb);
        check_val("t4_code_kept", {28'd0, kif.key_code}, 32'h9);
        s0 = n_strobe;
        keys[0] = 1'b1;
        exp_q.push_back(4'h0);
        wait_strobe(s0 + 1, 100);
        check_val("t4_code", {28'd0, kif.key_code}, 32'h0);
        keys[0] = 1'b0;
        wait_release(100);

        // 5: ghost pattern in column 3 is ignored
        s0 = n_strobe;
        keys[7]  = 1'b1;
        keys[15] = 1'b1;
        repeat (80) tick();
        wait_col(3, 64);
        wait_col(0, 64);
        check_val("t5_strobes", n_strobe, s0);
        check_val("t5_code", {28'd0, kif.key_code}, 32'h0);
        check_val("t5_held", {31'd0, kif.key_held}, 32'd0);
        keys[7]  = 1'b0;
        keys[15] = 1'b0;

        // 6: asynchronous reset while held
        s0 = n_strobe;
        keys[9] = 1'b1;
        exp_q.push_back(4'h9);
        wait_strobe(s0 + 1, 100);
        repeat (3) tick();
        check_val("t6_held_before", {31'd0, kif.key_held}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_val("t6_col", {28'd0, kif.col_out}, 32'he);
        check_val("t6_held", {31'd0, kif.key_held}, 32'd0);
        check_val("t6_code", {28'd0, kif.key_code}, 32'h0);
        check_val("t6_valid", {31'd0, kif.key_valid}, 32'd0);
        keys[9] = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        check_val("t6_restart_col", {28'd0, kif.col_out}, 32'he);
        repeat (40) tick();
        check_val("t6_no_strobe", n_strobe, s0 + 1);
        check_val("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
